fsm_pattern_seq: RTL and testbench
==================================

// Module: fsm_pattern_seq
// PURPOSE
//  Parametrised state-sequenced pattern generator; generalises the 1-bit toggling FSM/decoder.
//  A CW-bit state counter steps through DEPTH states; x is decoded from a writable pattern table.
//  Adds start/stop control, per-cycle enable, and one-shot or continuous mode.
//  Sits between the control plane (table writes) and datapath strobes/enables driven by x.
// PARAMETERS
//  WIDTH   1   width of x and of each pattern-table entry
//  DEPTH   2   number of sequence states; must be >= 2
//  CW      $clog2(DEPTH), localparam   state / address width
// PORTS
//  clk      in   1      clock; all logic on posedge
//  rst_n    in   1      asynchronous, active-low reset
//  en       in   1      advance enable while running; 0 holds the state
//  mode     in   1      0 = continuous (wrap), 1 = one-shot; sampled on start
//  start    in   1      pulse; leave IDLE and begin the sequence at state 0
//  stop     in   1      pulse; abort to IDLE
//  wr_en    in   1      pattern-table write strobe
//  wr_addr  in   CW     table entry to write
//  wr_data  in   WIDTH  table entry data
//  x        out  WIDTH  decoded pattern output (combinational from state/table)
//  state    out  CW     current sequence index
//  busy     out  1      1 while in RUN
//  done     out  1      one-cycle pulse when a one-shot run completes
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, state=0, busy=0, done=0, x=0.
//   Table: entry 0 = all ones, all other entries = 0 (default: x=1 in state 0, else 0).
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: state=0, x=0.
//    - start=1 & stop=0: go to RUN next cycle with state=0.
//    - mode is latched into mode_q at this point.
//    - start with stop in the same cycle: stays IDLE.
//  - RUN: busy=1, x=table[state].
//    - stop=1 (highest priority): go to IDLE next cycle, state=0.
//    - en=1 & state<DEPTH-1: state+1.
//    - en=1 & state==DEPTH-1 & mode_q=0: state wraps to 0, stays RUN.
//    - en=1 & state==DEPTH-1 & mode_q=1: go to DONE, state=0.
//    - en=0: state holds.
//    - start in RUN is ignored; mode changes in RUN are ignored.
//  - DONE: done=1 and x=0 for exactly one cycle, then IDLE unconditionally.
//    - start and stop are ignored in DONE.
//  Latency: start at cycle N gives busy=1 and x=table[0] at cycle N+1.
//   Each en=1 cycle advances exactly one state.
//  Table writes:
//  - Registered and accepted in any FSM state.
//  - A write to the currently displayed entry changes x from the next cycle.
//  - wr_addr >= DEPTH: write is dropped.
//  - Writes do not affect state or FSM.
//  Reset asserted mid-run: immediate return to the reset values above, table included.
//  state never exceeds DEPTH-1, including when DEPTH is not a power of two.
// CONFIGURATION
//  FSM_PATSEQ_WRAPCNT_EN defined:
//  - Adds output port wraps [15:0]: count of continuous-mode wraps (DEPTH-1 -> 0).
//  - wraps saturates at 16'hFFFF, clears to 0 on an accepted start, resets to 0.
//  FSM_PATSEQ_WRAPCNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset, DEPTH=2, mode=0, en=1, start pulse -> busy=1; x alternates 1,0,1,0; state 0,1,0,1.
//  2 DEPTH=5, WIDTH=4, mode=1, table=1,2,4,8,F, en=1, start
//    -> x=1,2,4,8,F on 5 cycles; then done=1 for one cycle with x=0; then busy=0.
//  3 RUN at state 2, en=0 for 3 cycles -> state/x hold; en=1 -> state 3.
//  4 RUN at state 3, stop=1 -> next cycle IDLE, state=0, x=0.
//    Separately, start with stop in the same cycle from IDLE -> stays IDLE.
//  5 wr_en to current state with data A -> x=A next cycle; wr_addr=DEPTH -> table unchanged.
//  6 rst_n low mid-run (async, between edges) -> x=0, busy=0 immediately.
//    With FSM_PATSEQ_WRAPCNT_EN: 3 full continuous periods -> wraps=3.

Source files
------------

// File: rtl/fsm_pattern_seq.sv
// ---------------------------------------------------------------------------
// fsm_pattern_seq
//   State-sequenced pattern generator. A CW-bit index walks through DEPTH
//   states while running; x is looked up from a writable pattern table at
//   the current index. Supports start/stop control, per-cycle advance enable
//   and continuous (wrap) or one-shot operation.
//
// Parameters
//   WIDTH   width of x and of each pattern-table entry
//   DEPTH   number of sequence states (>= 2)
//   CW      index / address width, $clog2(DEPTH)
//
// Ports
//   clk       clock, all logic on posedge
//   rst_n     asynchronous active-low reset (table included)
//   en        advance enable while running; 0 holds the index
//   mode      0 = continuous, 1 = one-shot; captured when a start is accepted
//   start     pulse: leave IDLE and run from index 0
//   stop      pulse: abort to IDLE (wins over everything in RUN)
//   wr_en     pattern-table write strobe, accepted in any FSM state
//   wr_addr   table entry to write; addresses >= DEPTH are dropped
//   wr_data   table entry data
//   x         table[state] while running, else 0 (combinational)
//   state     current sequence index
//   busy      1 while running
//   done      one-cycle pulse when a one-shot run completes
//   wraps     (FSM_PATSEQ_WRAPCNT_EN only) saturating count of
//             continuous-mode wraps, cleared on an accepted start
//
// Build option
//   FSM_PATSEQ_WRAPCNT_EN : adds the wraps output and its counter.
// ---------------------------------------------------------------------------
module fsm_pattern_seq #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] x,
  output logic [CW-1:0]    state,
`ifdef FSM_PATSEQ_WRAPCNT_EN
  output logic [15:0]      wraps,
`endif
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  fsm_e             fsm_q,   fsm_d;
  logic [CW-1:0]    state_q, state_d;
  logic             mode_q,  mode_d;
  logic [WIDTH-1:0] table_q [DEPTH];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    mode_d  = mode_q;
    unique case (fsm_q)
      S_IDLE: begin
        state_d = '0;
        // A start that collides with stop is not accepted.
        if (start && !stop) begin
          fsm_d  = S_RUN;
          mode_d = mode;
        end
      end
      S_RUN: begin
        if (stop) begin
          fsm_d   = S_IDLE;
          state_d = '0;
        end else if (en) begin
          if (state_q == LAST) begin
            state_d = '0;
            if (mode_q) fsm_d = S_DONE;
          end else begin
            state_d = state_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        fsm_d   = S_IDLE;
        state_d = '0;
      end
      default: begin
        fsm_d   = S_IDLE;
        state_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM / index registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pattern table. Per-entry address decode only matches 0..DEPTH-1, so
  // out-of-range writes fall through naturally, also for non-power-of-two
  // DEPTH.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the table is a small flop array with a defined reset image
    // (entry 0 all ones, rest zero), so it is reset like any other register
    // rather than treated as an uninitialised RAM.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= (i == 0) ? '1 : '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == CW'(i))) table_q[i] <= wr_data;
      end
    end
  end

`ifdef FSM_PATSEQ_WRAPCNT_EN
  // -------------------------------------------------------------------------
  // Continuous-mode wrap counter (saturating).
  // -------------------------------------------------------------------------
  logic [15:0] wraps_q, wraps_d;
  logic        start_acc;
  logic        wrap_evt;

  always_comb begin
    start_acc = (fsm_q == S_IDLE) && start && !stop;
    wrap_evt  = (fsm_q == S_RUN) && !stop && en && (state_q == LAST) && !mode_q;
    wraps_d   = wraps_q;
    if (start_acc) begin
      wraps_d = '0;
    end else if (wrap_evt && (wraps_q != 16'hFFFF)) begin
      wraps_d = wraps_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wraps_q <= '0;
    else        wraps_q <= wraps_d;
  end

  assign wraps = wraps_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy  = (fsm_q == S_RUN);
  assign done  = (fsm_q == S_DONE);
  assign state = state_q;
  assign x     = busy ? table_q[state_q] : '0;

endmodule

// File: tb/tb_fsm_pattern_seq.sv
// ---------------------------------------------------------------------------
// tb_fsm_pattern_seq
//   Directed bench for fsm_pattern_seq. Two instances share the control
//   inputs: dut_a (DEPTH=2, WIDTH=1, default table) and dut_b (DEPTH=5,
//   WIDTH=4, programmable table). Table-driven vectors cover the toggling
//   and one-shot sequences; hand-written sequences cover hold, stop,
//   start/stop collision, table writes, continuous wrap and async reset.
// ---------------------------------------------------------------------------
module tb_fsm_pattern_seq;

  logic clk;
  logic rst_n;
  logic en, mode, start, stop;

  // dut_a: DEPTH=2, WIDTH=1
  logic       wr_en_a;
  logic [0:0] wr_addr_a;
  logic [0:0] wr_data_a;
  logic [0:0] x_a;
  logic [0:0] state_a;
  logic       busy_a, done_a;

  // dut_b: DEPTH=5, WIDTH=4
  logic       wr_en_b;
  logic [2:0] wr_addr_b;
  logic [3:0] wr_data_b;
  logic [3:0] x_b;
  logic [2:0] state_b;
  logic       busy_b, done_b;

`ifdef FSM_PATSEQ_WRAPCNT_EN
  logic [15:0] wraps_a, wraps_b;
`endif

  int total = 0;
  int bad   = 0;

  fsm_pattern_seq #(.WIDTH(1), .DEPTH(2)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .wr_en   (wr_en_a),
    .wr_addr (wr_addr_a),
    .wr_data (wr_data_a),
    .x       (x_a),
    .state   (state_a),
`ifdef FSM_PATSEQ_WRAPCNT_EN
    .wraps   (wraps_a),
`endif
    .busy    (busy_a),
    .done    (done_a)
  );

  fsm_pattern_seq #(.WIDTH(4), .DEPTH(5)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .wr_en   (wr_en_b),
    .wr_addr (wr_addr_b),
    .wr_data (wr_data_b),
    .x       (x_b),
    .state   (state_b),
`ifdef FSM_PATSEQ_WRAPCNT_EN
    .wraps   (wraps_b),
`endif
    .busy    (busy_b),
    .done    (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       en;
    logic       mode;
    logic       sel;      // 0 = check dut_a, 1 = check dut_b
    logic       busy;
    logic [2:0] state;
    logic [3:0] x;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag, input logic b, input logic [2:0] s,
                         input logic [3:0] xv, input logic d);
    check({tag, ".busy_b"},  {31'd0, busy_b}, {31'd0, b});
    check({tag, ".state_b"}, {29'd0, state_b}, {29'd0, s});
    check({tag, ".x_b"},     {28'd0, x_b},     {28'd0, xv});
    check({tag, ".done_b"},  {31'd0, done_b},  {31'd0, d});
  endtask

  task automatic apply(input vec_t v, input int idx);
    start = v.start;
    stop  = v.stop;
    en    = v.en;
    mode  = v.mode;
    step();
    if (v.sel) begin
      check_b($sformatf("vec%0d", idx), v.busy, v.state, v.x, v.done);
    end else begin
      check($sformatf("vec%0d.busy_a", idx),  {31'd0, busy_a},  {31'd0, v.busy});
      check($sformatf("vec%0d.state_a", idx), {31'd0, state_a}, {29'd0, v.state});
      check($sformatf("vec%0d.x_a", idx),     {31'd0, x_a},     {28'd0, v.x});
      check($sformatf("vec%0d.done_a", idx),  {31'd0, done_a},  {31'd0, v.done});
    end
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0;
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr_b(input logic [2:0] addr, input logic [3:0] data);
    wr_en_b   = 1'b1;
    wr_addr_b = addr;
    wr_data_b = data;
    step();
    wr_en_b   = 1'b0;
  endtask

  task automatic load_b_table();
    wr_b(3'd0, 4'h1);
    wr_b(3'd1, 4'h2);
    wr_b(3'd2, 4'h4);
    wr_b(3'd3, 4'h8);
    wr_b(3'd4, 4'hF);
  endtask

  logic [3:0] tbl_b [5];

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0;
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;

    //                start stop en mode sel busy state  x     done
    // DEPTH=2 continuous toggle on dut_a
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h0, 1'b0});
    // DEPTH=5 one-shot on dut_b (table 1,2,4,8,F); mode/start changes in RUN ignored
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'h1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 4'h2, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'h4, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'h8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'hF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 1'b1});
    // start while in DONE is ignored: back to IDLE
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0});

    // ---- 1: reset state, then DEPTH=2 toggle ----
    #3;
    do_reset();
    check("rst.busy_a",  {31'd0, busy_a},  32'd0);
    check("rst.x_a",     {31'd0, x_a},     32'd0);
    check("rst.state_a", {31'd0, state_a}, 32'd0);
    check("rst.done_a",  {31'd0, done_a},  32'd0);
    check_b("rst", 1'b0, 3'd0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) apply(vecs[i], i);

    // ---- 2: DEPTH=5 one-shot ----
    do_reset();
    load_b_table();
    for (int i = 4; i < vecs.size(); i++) apply(vecs[i], i);

    // ---- 3: hold with en=0 ----
    do_reset();
    load_b_table();
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    check_b("t3.start", 1'b1, 3'd0, 4'h1, 1'b0);
    step();
    step();
    check_b("t3.s2", 1'b1, 3'd2, 4'h4, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_b($sformatf("t3.hold%0d", i), 1'b1, 3'd2, 4'h4, 1'b0);
    end
    en = 1'b1;
    step();
    check_b("t3.resume", 1'b1, 3'd3, 4'h8, 1'b0);

    // ---- 4: stop from RUN, start+stop collision in IDLE ----
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_b("t4.stop", 1'b0, 3'd0, 4'h0, 1'b0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_b("t4.collide", 1'b0, 3'd0, 4'h0, 1'b0);
    step();
    check_b("t4.idle", 1'b0, 3'd0, 4'h0, 1'b0);

    // ---- 5: table write to displayed entry, dropped out-of-range write ----
    start = 1'b1; mode = 1'b0; en = 1'b0;
    step();
    start = 1'b0;
    check_b("t5.start", 1'b1, 3'd0, 4'h1, 1'b0);
`ifdef FSM_PATSEQ_WRAPCNT_EN
    check("t5.wraps_clr", {16'd0, wraps_b}, 32'd0);
`endif
    wr_b(3'd0, 4'hA);
    check_b("t5.wr_cur", 1'b1, 3'd0, 4'hA, 1'b0);
    wr_b(3'd5, 4'h3);
    check_b("t5.wr_oob", 1'b1, 3'd0, 4'hA, 1'b0);
    wr_b(3'd7, 4'h5);
    check_b("t5.wr_oob7", 1'b1, 3'd0, 4'hA, 1'b0);

    // continuous wrap over 3 full periods: index never leaves 0..4
    tbl_b[0] = 4'hA; tbl_b[1] = 4'h2; tbl_b[2] = 4'h4; tbl_b[3] = 4'h8; tbl_b[4] = 4'hF;
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("t5.wrap_state%0d", k), {29'd0, state_b}, (k + 1) % 5);
      check($sformatf("t5.wrap_x%0d", k), {28'd0, x_b}, {28'd0, tbl_b[(k + 1) % 5]});
    end
    check("t5.wrap_busy", {31'd0, busy_b}, 32'd1);
`ifdef FSM_PATSEQ_WRAPCNT_EN
    check("t5.wraps3", {16'd0, wraps_b}, 32'd3);
`endif

    // ---- 6: async reset mid-run, table restored ----
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_b("t6.async", 1'b0, 3'd0, 4'h0, 1'b0);
    check("t6.busy_a", {31'd0, busy_a}, 32'd0);
    check("t6.x_a",    {31'd0, x_a},    32'd0);
`ifdef FSM_PATSEQ_WRAPCNT_EN
    check("t6.wraps", {16'd0, wraps_b}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    start = 1'b1; en = 1'b0; mode = 1'b0;
    step();
    start = 1'b0;
    check_b("t6.table_rst", 1'b1, 3'd0, 4'hF, 1'b0);
    check("t6.x_a_tbl", {31'd0, x_a}, 32'd1);
    en = 1'b1;
    step();
    check_b("t6.entry1", 1'b1, 3'd1, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
